weight_load_ctrl: RTL

- Sequences one full weight-tile load from the on-chip weight SRAM into the weight preprocessing unit.
- Issues column-major read addresses 0..MEM_SIZE-1, one per cycle, and presents each returned weight with its address.
- Drives the preprocessing unit's load_mem_done low only on cycles carrying a valid weight.
- Honours a downstream stall, supports abort, and reports column/tile completion to the top-level scheduler.

---
 rtl/weight_load_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/weight_load_ctrl.sv
// -----------------------------------------------------------------------------
// weight_load_ctrl
//   Sequences one full weight-tile load from the weight SRAM into the weight
//   preprocessing unit (WPU). Read addresses 0..MEM_SIZE-1 are issued in
//   column-major order, one per cycle, and each returned weight is presented
//   to the WPU together with its address. A downstream stall freezes the
//   pipeline, abort drops the load, and column/tile completion is reported.
//
// Optional feature macro: WLC_PERF_CNT_EN
//   Adds stall_cycles / load_cycles performance counters (16-bit, saturating).
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start               one-cycle pulse, begins a tile load when idle
//   abort               terminates the load, highest priority
//   stall               downstream not ready this cycle
//   wmem_rd_en/addr     SRAM read request
//   wmem_rd_data        SRAM read data, valid one cycle after rd_en, held after
//   wpu_weight/addr     weight and its address to the WPU
//   wpu_load_mem_done   0 on the cycle a weight is consumed, 1 otherwise
//   col_done            pulse when the last row of a column is consumed
//   col_idx             column of the current/last consumed weight
//   busy                high while loading
//   done                one-cycle pulse once the full tile is consumed
//   stall_cycles        (WLC_PERF_CNT_EN) LOAD cycles with stall high
//   load_cycles         (WLC_PERF_CNT_EN) cycles spent in LOAD
// -----------------------------------------------------------------------------
module weight_load_ctrl #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned MEM_SIZE   = SIZE * SIZE,
  parameter int unsigned ADDR_WIDTH = $clog2(MEM_SIZE),
  parameter int unsigned COL_WIDTH  = $clog2(SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  stall,
  output logic                  wmem_rd_en,
  output logic [ADDR_WIDTH-1:0] wmem_rd_addr,
  input  logic [7:0]            wmem_rd_data,
  output logic [7:0]            wpu_weight,
  output logic [ADDR_WIDTH-1:0] wpu_addr,
  output logic                  wpu_load_mem_done,
  output logic                  col_done,
  output logic [COL_WIDTH-1:0]  col_idx,
  output logic                  busy,
  output logic                  done
`ifdef WLC_PERF_CNT_EN
  ,
  output logic [15:0]           stall_cycles,
  output logic [15:0]           load_cycles
`endif
);

  // One extra bit so the counters can reach MEM_SIZE without wrapping.
  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [CNT_WIDTH-1:0]  issue_cnt_q, issue_cnt_d;
  logic [CNT_WIDTH-1:0]  cons_cnt_q, cons_cnt_d;
  logic                  data_valid_q, data_valid_d;
  logic [ADDR_WIDTH-1:0] wpu_addr_q;
  logic                  start_acc;
  logic                  consume;

  // A start is only honoured from IDLE and always loses to abort.
  assign start_acc = start && !abort && (state_q == ST_IDLE);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start_acc) state_d = ST_LOAD;
      ST_LOAD: begin
        if (abort) state_d = ST_IDLE;
        else if (consume && (cons_cnt_q == CNT_WIDTH'(MEM_SIZE - 1))) state_d = ST_FIN;
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / handshake logic. Abort also suppresses the consume so an aborted
  // load never reports a column or tile completion.
  always_comb begin
    wmem_rd_en        = 1'b0;
    consume           = 1'b0;
    wpu_load_mem_done = 1'b1;
    col_done          = 1'b0;
    busy              = 1'b0;
    done              = 1'b0;
    if (state_q == ST_LOAD) begin
      busy       = 1'b1;
      wmem_rd_en = !stall && !abort && (issue_cnt_q < CNT_WIDTH'(MEM_SIZE));
      consume    = data_valid_q && !stall && !abort;
    end
    if (state_q == ST_FIN) done = 1'b1;
    wpu_load_mem_done = !consume;
    col_done = consume &&
               ((wpu_addr_q % ADDR_WIDTH'(SIZE)) == ADDR_WIDTH'(SIZE - 1));
  end

  // Issue / consume counters and the read-data valid flag.
  always_comb begin
    issue_cnt_d  = issue_cnt_q;
    cons_cnt_d   = cons_cnt_q;
    data_valid_d = data_valid_q;
    if (abort || start_acc) begin
      issue_cnt_d  = '0;
      cons_cnt_d   = '0;
      data_valid_d = 1'b0;
    end else begin
      if (wmem_rd_en) issue_cnt_d = issue_cnt_q + CNT_WIDTH'(1);
      if (consume)    cons_cnt_d  = cons_cnt_q + CNT_WIDTH'(1);
      // SRAM holds its output while stalled, so the pending weight stays valid.
      if (wmem_rd_en)  data_valid_d = 1'b1;
      else if (!stall) data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt_q  <= '0;
      cons_cnt_q   <= '0;
      data_valid_q <= 1'b0;
    end else begin
      issue_cnt_q  <= issue_cnt_d;
      cons_cnt_q   <= cons_cnt_d;
      data_valid_q <= data_valid_d;
    end
  end

  // Address pipeline: pairs each returned weight with the address that read it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)             wpu_addr_q <= '0;
    else if (wmem_rd_en) wpu_addr_q <= wmem_rd_addr;
  end

  assign wmem_rd_addr = issue_cnt_q[ADDR_WIDTH-1:0];
  assign wpu_addr     = wpu_addr_q;
  assign wpu_weight   = wmem_rd_data;
  assign col_idx      = COL_WIDTH'(wpu_addr_q / ADDR_WIDTH'(SIZE));

`ifdef WLC_PERF_CNT_EN
  logic [15:0] stall_cycles_q, load_cycles_q;

  // Saturating performance counters, cleared on an accepted start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles_q <= '0;
      load_cycles_q  <= '0;
    end else if (start_acc) begin
      stall_cycles_q <= '0;
      load_cycles_q  <= '0;
    end else if (state_q == ST_LOAD) begin
      if (load_cycles_q != 16'hFFFF) load_cycles_q <= load_cycles_q + 16'd1;
      if (stall && (stall_cycles_q != 16'hFFFF)) stall_cycles_q <= stall_cycles_q + 16'd1;
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign load_cycles  = load_cycles_q;
`endif

endmodule
